// File: rtl/key_debounce_filter_if.sv
// Key pin / debounced-output bundle for key_debounce_filter.
// master drives the raw key level; slave is the debouncer itself.
interface key_debounce_filter_if;
    logic key_in;
    logic key_flag;
    logic key_state;

    modport master (
        output key_in,
        input  key_flag,
        input  key_state
    );

    modport slave (
        input  key_in,
        output key_flag,
        output key_state
    );
endinterface

// File: rtl/key_debounce_filter.sv
// Active-low push-button debouncer with a one-cycle event flag and a debounced level.
// Define KEY_FILTER_PRESS_ONLY_EN to suppress the flag on confirmed releases.
module key_debounce_filter #(
    parameter int unsigned CNT_MAX = 999_999,
    parameter int unsigned CNT_W   = 20
) (
    input  logic                 Clk,
    input  logic                 Rst,
    key_debounce_filter_if.slave key_bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FILTER0 = 2'b01,
        DOWN    = 2'b10,
        FILTER1 = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sync_q, sync_d;
    logic             key_flag_q, key_flag_d;
    logic             key_state_q, key_state_d;
    logic             nedge;
    logic             pedge;
    logic             cnt_done;

    // sync_q[0]/[1] are the metastability pair, sync_q[2] is the delayed copy for edge detection
    always_comb begin
        sync_d = {sync_q[1:0], key_bus.key_in};
    end

    assign nedge    =  sync_q[2] & ~sync_q[1];
    assign pedge    = ~sync_q[2] &  sync_q[1];
    assign cnt_done = (cnt_q == CNT_LAST);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q      <= 3'b111;
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_flag_q  <= 1'b0;
            key_state_q <= 1'b1;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_flag_q  <= key_flag_d;
            key_state_q <= key_state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (nedge) state_d = FILTER0;
            end
            FILTER0: begin
                if (pedge)         state_d = IDLE;
                else if (cnt_done) state_d = DOWN;
            end
            DOWN: begin
                if (pedge) state_d = FILTER1;
            end
            FILTER1: begin
                if (nedge)         state_d = DOWN;
                else if (cnt_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // An edge in the same cycle as the final count wins, so late bounces are still rejected
    always_comb begin
        cnt_d       = '0;
        key_flag_d  = 1'b0;
        key_state_d = key_state_q;
        case (state_q)
            IDLE, DOWN: begin
                cnt_d = '0;
            end
            FILTER0: begin
                if (!pedge) begin
                    if (cnt_done) begin
                        key_flag_d  = 1'b1;
                        key_state_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FILTER1: begin
                if (!nedge) begin
                    if (cnt_done) begin
`ifdef KEY_FILTER_PRESS_ONLY_EN
                        key_flag_d  = 1'b0;
`else
                        key_flag_d  = 1'b1;
`endif
                        key_state_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                key_state_d = 1'b1;
            end
        endcase
    end

    assign key_bus.key_flag  = key_flag_q;
    assign key_bus.key_state = key_state_q;

endmodule

// File: tb/tb_key_debounce_filter.sv
// Directed bench for key_debounce_filter with a scoreboard of expected flag pulses.
// Honours KEY_FILTER_PRESS_ONLY_EN when building expectations.
module tb_key_debounce_filter;

    localparam int CNT_MAX = 999;
    localparam int CNT_W   = 10;
    localparam int LAT     = CNT_MAX + 4;
    localparam int GAP     = 1025;

    typedef struct {
        int   cyc;
        logic lvl;
    } exp_t;

    logic clk;
    logic rst;
    int   cycle;
    int   flag_count;
    int   assert_count;
    int   fail_count;
    exp_t exp_q[$];

    key_debounce_filter_if bus ();

    key_debounce_filter #(
        .CNT_MAX (CNT_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .Clk     (clk),
        .Rst     (rst),
        .key_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Caller must be sitting 1 time unit after a rising edge; leaves it there again
    task automatic applyStimulus(input logic level, input int cycles);
        bus.key_in = level;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic expectFlag(input int cyc, input logic lvl);
        exp_t e;
        e.cyc = cyc;
        e.lvl = lvl;
        exp_q.push_back(e);
    endtask

    // Every observed pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.key_flag === 1'b1) begin
                flag_count++;
                assert_count++;
                assert (exp_q.size() != 0) else begin
                    fail_count++;
                    $error("[TB] FAIL unexpected_flag: observed pulse at cycle %0d, expected none", cycle);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("flag_cycle", cycle, e.cyc);
                    checkOutput("flag_level", 32'(bus.key_state), 32'(e.lvl));
                end
            end
        end
    end

    initial begin
        int n;
        int base;
        int per_cycle;
        flag_count   = 0;
        assert_count = 0;
        fail_count   = 0;
        rst          = 1'b1;
        bus.key_in   = 1'b1;
`ifdef KEY_FILTER_PRESS_ONLY_EN
        per_cycle = 1;
`else
        per_cycle = 2;
`endif

        $display("[TB] reset phase");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_flag", 32'(bus.key_flag), 0);
            checkOutput("reset_state", 32'(bus.key_state), 1);
        end
        rst = 1'b0;
        applyStimulus(1'b1, 5);
        checkOutput("post_reset_flag", 32'(bus.key_flag), 0);
        checkOutput("post_reset_state", 32'(bus.key_state), 1);
        checkOutput("post_reset_fsm", 32'(dut.state_q), 0);

        $display("[TB] bounced press");
        base = flag_count;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, $urandom_range(150, 50));
            applyStimulus(1'b1, $urandom_range(150, 50));
        end
        expectFlag(cycle + LAT, 1'b0);
        applyStimulus(1'b0, 2000);
        checkOutput("press_flags", flag_count - base, 1);
        checkOutput("press_state", 32'(bus.key_state), 0);

        $display("[TB] bounced release");
        base = flag_count;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, $urandom_range(150, 50));
            applyStimulus(1'b0, $urandom_range(150, 50));
        end
`ifndef KEY_FILTER_PRESS_ONLY_EN
        expectFlag(cycle + LAT, 1'b1);
`endif
        applyStimulus(1'b1, 2000);
        checkOutput("release_flags", flag_count - base, per_cycle - 1);
        checkOutput("release_state", 32'(bus.key_state), 1);

        $display("[TB] short glitch");
        base = flag_count;
        applyStimulus(1'b0, 500);
        applyStimulus(1'b1, 1100);
        checkOutput("glitch_flags", flag_count - base, 0);
        checkOutput("glitch_state", 32'(bus.key_state), 1);
        checkOutput("glitch_fsm", 32'(dut.state_q), 0);

        $display("[TB] release coinciding with final count");
        base = flag_count;
        applyStimulus(1'b0, CNT_MAX + 1);
        applyStimulus(1'b1, 1100);
        checkOutput("edge_wins_flags", flag_count - base, 0);
        checkOutput("edge_wins_state", 32'(bus.key_state), 1);
        checkOutput("edge_wins_fsm", 32'(dut.state_q), 0);

        $display("[TB] release one cycle after final count");
        base = flag_count;
        n = cycle;
        expectFlag(n + LAT, 1'b0);
        applyStimulus(1'b0, CNT_MAX + 2);
`ifndef KEY_FILTER_PRESS_ONLY_EN
        expectFlag(cycle + LAT, 1'b1);
`endif
        applyStimulus(1'b1, 2000);
        checkOutput("just_in_time_flags", flag_count - base, per_cycle);
        checkOutput("just_in_time_state", 32'(bus.key_state), 1);

        $display("[TB] reset during press filter");
        base = flag_count;
        applyStimulus(1'b0, 503);
        checkOutput("mid_filter_cnt", 32'(dut.cnt_q), 500);
        checkOutput("mid_filter_fsm", 32'(dut.state_q), 1);
        rst = 1'b1;
        applyStimulus(1'b1, 1);
        checkOutput("abort_fsm", 32'(dut.state_q), 0);
        checkOutput("abort_cnt", 32'(dut.cnt_q), 0);
        checkOutput("abort_flag", 32'(bus.key_flag), 0);
        checkOutput("abort_state", 32'(bus.key_state), 1);
        rst = 1'b0;
        applyStimulus(1'b1, 1100);
        checkOutput("abort_flags", flag_count - base, 0);

        $display("[TB] three press/release cycles");
        base = flag_count;
        for (int i = 0; i < 3; i++) begin
            expectFlag(cycle + LAT, 1'b0);
            applyStimulus(1'b0, GAP);
            checkOutput("cycle_press_state", 32'(bus.key_state), 0);
`ifndef KEY_FILTER_PRESS_ONLY_EN
            expectFlag(cycle + LAT, 1'b1);
`endif
            applyStimulus(1'b1, GAP);
            checkOutput("cycle_release_state", 32'(bus.key_state), 1);
        end
        checkOutput("cycle_flags", flag_count - base, 3 * per_cycle);

        applyStimulus(1'b1, 10);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/key_debounce_filter.md
Name: key_debounce_filter

Overview:
- Debounces one active-low mechanical push-button input sampled on the 50 MHz system clock.
- Emits a one-cycle event flag when a press or release is confirmed stable for the debounce window.
- Also outputs a level showing the current debounced key state.
- Sits between the board key pin and application logic (LED control, counters).

Parameters:
- CNT_MAX, 999_999, debounce window length minus one in clock cycles (20 ms at 50 MHz). Benches override to a small value.
- CNT_W, 20, counter width; must hold CNT_MAX.

Ports:
- Clk  input  1  system clock, all logic on rising edge.
- Rst  input  1  synchronous, active-high reset.
- key_in  input  1  raw asynchronous key level; 1 = released, 0 = pressed.
- key_flag  output  1  one-cycle pulse when a debounced edge is confirmed.
- key_state  output  1  debounced level; 1 = released, 0 = pressed.

Behaviour:
- Synchroniser: key_in passes through two flip-flops (s1, s2), then one more stage (s3). Reset value of all three is 1.
- Edge detect: nedge = s3 & ~s2 (falling, press start); pedge = ~s3 & s2 (rising, release start).
- State machine, encoded in 2 bits. Reset state is IDLE.
  - IDLE (released, stable): on nedge, clear cnt and go to FILTER0.
  - FILTER0 (press candidate):
    - pedge before cnt == CNT_MAX: return to IDLE, clear cnt, no flag.
    - cnt == CNT_MAX with no pedge in that cycle: key_flag=1 for that cycle, key_state=0, clear cnt, go to DOWN.
    - Otherwise: cnt += 1.
  - DOWN (pressed, stable): on pedge, clear cnt and go to FILTER1.
  - FILTER1 (release candidate):
    - nedge before cnt == CNT_MAX: return to DOWN, clear cnt, no flag.
    - cnt == CNT_MAX: key_flag=1 for that cycle, key_state=1, clear cnt, go to IDLE.
    - Otherwise: cnt += 1.
- Edge and CNT_MAX in the same cycle: the edge wins; bounce is rejected.
- Latency from the last input bounce to key_flag: 3 synchroniser cycles + CNT_MAX + 1 cycles.
- key_flag and key_state are registered. They change in the same cycle; key_state already holds the new value while key_flag is high.
- Counter only runs in the FILTER states. It holds 0 elsewhere and never wraps.
- Reset values: key_flag=0, key_state=1, cnt=0, state=IDLE, synchroniser=1.
- Reset asserted mid-filter aborts immediately with no flag. A key still held low after reset is detected as a new press through the nedge path only if a falling edge occurs. Reset does not infer the pressed state.
- Illegal state encoding returns to IDLE with outputs at reset values.

Optional Feature:
- Macro: KEY_FILTER_PRESS_ONLY_EN.
- Defined: key_flag pulses only on a confirmed press (FILTER0 -> DOWN). Confirmed release updates key_state to 1 without a flag.
- Undefined (default): key_flag pulses on both confirmed press and confirmed release.
- key_state behaviour is identical in both builds.

Test Plan:
- Reset held 10 cycles with key_in=1 -> key_flag=0, key_state=1 throughout and after release of Rst.
- CNT_MAX=999. Drive key_in low with 8 bounces (toggle intervals 1000–3000 ns), then hold low 40 us -> exactly one key_flag pulse, key_state=0. The pulse comes 1000 cycles + 3 sync cycles after the final falling transition.
- From pressed, 8 release bounces then hold high 40 us -> one key_flag pulse, key_state=1 (no pulse when KEY_FILTER_PRESS_ONLY_EN is defined).
- Low glitch of 500 cycles (< CNT_MAX) from IDLE -> no key_flag, key_state stays 1, FSM back in IDLE.
- Assert Rst at cnt=500 during FILTER0 -> next cycle state=IDLE, cnt=0, key_flag=0, key_state=1.
- Three full press/release cycles with 20.5 ms-equivalent gaps -> exactly 6 key_flag pulses, alternating key_state 0/1.
